// File: rtl/ad9959_pkg.sv
// ---------------------------------------------------------------------------
// ad9959_pkg
// Shared definitions for the AD9959 card controllers (write controller and
// readback engine):
//   - register address map of the AD9959
//   - host command code for a register read
//   - readback state encoding
//   - reg_bytes(): register width in bytes, 0 for an unmapped address
// ---------------------------------------------------------------------------
package ad9959_pkg;

  // Register address map
  localparam logic [4:0] CSR   = 5'h00;
  localparam logic [4:0] FR1   = 5'h01;
  localparam logic [4:0] FR2   = 5'h02;
  localparam logic [4:0] CFR   = 5'h03;
  localparam logic [4:0] CFTW0 = 5'h04;
  localparam logic [4:0] CPOW0 = 5'h05;
  localparam logic [4:0] ACR   = 5'h06;
  localparam logic [4:0] LSRR  = 5'h07;
  localparam logic [4:0] RDW   = 5'h08;
  localparam logic [4:0] FDW   = 5'h09;
  localparam logic [4:0] CW1   = 5'h0A;
  localparam logic [4:0] CW2   = 5'h0B;
  localparam logic [4:0] CW3   = 5'h0C;
  localparam logic [4:0] CW4   = 5'h0D;
  localparam logic [4:0] CW5   = 5'h0E;
  localparam logic [4:0] CW6   = 5'h0F;
  localparam logic [4:0] CW7   = 5'h10;
  localparam logic [4:0] CW8   = 5'h11;
  localparam logic [4:0] CW9   = 5'h12;
  localparam logic [4:0] CW10  = 5'h13;
  localparam logic [4:0] CW11  = 5'h14;
  localparam logic [4:0] CW12  = 5'h15;
  localparam logic [4:0] CW13  = 5'h16;
  localparam logic [4:0] CW14  = 5'h17;
  localparam logic [4:0] CW15  = 5'h18;

  // Host command that routes the card pins to the readback engine
  localparam logic [4:0] CMD_READ = 5'h1F;

  // Readback engine states
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_INSTR = 2'd1,
    S_DATA  = 2'd2,
    S_GAP   = 2'd3
  } rbState_t;

  // Width of a register in bytes; 0 marks an address with no register.
  function automatic logic [2:0] reg_bytes(input logic [4:0] addr);
    logic [2:0] nb;
    nb = 3'd0;
    if (addr == CSR) begin
      nb = 3'd1;
    end else if ((addr == FR1) || (addr == CFR) || (addr == ACR)) begin
      nb = 3'd3;
    end else if ((addr == FR2) || (addr == CPOW0) || (addr == LSRR)) begin
      nb = 3'd2;
    end else if (addr <= CW15) begin
      // CFTW0 and RDW..CW15 are all 32-bit registers
      nb = 3'd4;
    end
    return nb;
  endfunction

endpackage

// File: rtl/ad9959_sipo.sv
// ---------------------------------------------------------------------------
// ad9959_sipo
// Serial-in parallel-out shift register, LSB-in: the first bit shifted in
// ends up as the most significant of the received bits.
// Ports:
//   clk_i      system clock
//   clear      load all zeros (has priority over enable)
//   enable     shift serialIn into bit 0
//   serialIn   serial data bit
//   shiftNext  value the register takes at the coming clock edge; lets the
//              owner capture a complete word on the same edge as its last bit
// ---------------------------------------------------------------------------
module ad9959_sipo #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              clear,
  input  logic              enable,
  input  logic              serialIn,
  output logic [DATA_W-1:0] shiftNext
);

  logic [DATA_W-1:0] shiftQ;

  always_comb begin
    shiftNext = shiftQ;
    if (clear) begin
      shiftNext = '0;
    end else if (enable) begin
      shiftNext = {shiftQ[DATA_W-2:0], serialIn};
    end
  end

  // Pure data register: it is cleared at the start of every transaction,
  // so it needs no reset of its own.
  always_ff @(posedge clk_i) begin
    shiftQ <= shiftNext;
  end

endmodule

// File: rtl/ad9959_readback.sv
// ---------------------------------------------------------------------------
// ad9959_readback
// Register readback engine for one AD9959 card. A read request sends the
// 8-bit read instruction {1, 00, addr} MSB first on SDIO_0, then collects
// 8/16/24/32 data bits from SDIO_2 (2-wire mode) into a right-justified,
// zero-extended 32-bit word. SCLK is ~clk_i outside this block, so the
// device samples in mid-cycle and the returned bit is captured at the
// clk_i edge that closes each data cycle.
// Parameters:
//   BRDIDX   card index; requests are taken only when sel_i == BRDIDX
//   CSB_GAP  cycles CSB stays high after a transaction before ready (>=1)
// Ports:
//   clk_i      system clock
//   reset_n_i  synchronous active-low reset
//   sel_i      card select
//   start_i    read request, taken only in IDLE
//   addr_i     register address, valid with start_i
//   sdio2_i    serial read data from the device
//   csb_o      chip select, active low
//   sdio0_o    instruction bit to the device
//   busy_o     pins owned (INSTR/DATA/GAP)
//   ready_o    idle, or this card not selected
//   data_o     last value read
//   valid_o    one-cycle pulse when data_o updates
//   err_o      one-cycle pulse when a request names an unmapped address
// ---------------------------------------------------------------------------
module ad9959_readback
  import ad9959_pkg::*;
#(
  parameter logic [3:0] BRDIDX  = 4'h0,
  parameter logic [3:0] CSB_GAP = 4'h2
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic [3:0]  sel_i,
  input  logic        start_i,
  input  logic [4:0]  addr_i,
  input  logic        sdio2_i,
  output logic        csb_o,
  output logic        sdio0_o,
  output logic        busy_o,
  output logic        ready_o,
  output logic [31:0] data_o,
  output logic        valid_o,
  output logic        err_o
);

  // Last count value of the gap phase
  localparam logic [4:0] GAP_LAST = 5'({1'b0, CSB_GAP} - 5'd1);

  rbState_t    state;
  rbState_t    stateNext;
  logic [4:0]  bitCnt;
  logic [4:0]  lastBit;
  logic [7:0]  instrSh;
  logic        selected;
  logic [2:0]  reqBytes;
  logic        accept;
  logic        reject;
  logic        shiftEn;
  logic        dataDone;
  logic [31:0] shiftNext;

  assign selected = (sel_i == BRDIDX);
  assign reqBytes = reg_bytes(addr_i);

  // Next-state and per-cycle strobes
  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    reject    = 1'b0;
    shiftEn   = 1'b0;
    dataDone  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_i && selected) begin
          if (reqBytes == 3'd0) begin
            reject = 1'b1;
          end else begin
            accept    = 1'b1;
            stateNext = S_INSTR;
          end
        end
      end
      S_INSTR: begin
        if (bitCnt == 5'd7) begin
          stateNext = S_DATA;
        end
      end
      S_DATA: begin
        shiftEn = 1'b1;
        if (bitCnt == lastBit) begin
          dataDone  = 1'b1;
          stateNext = S_GAP;
        end
      end
      S_GAP: begin
        if (bitCnt == GAP_LAST) begin
          stateNext = S_IDLE;
        end
      end
      default: begin
        stateNext = S_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state   <= S_IDLE;
      bitCnt  <= 5'd0;
      lastBit <= 5'd0;
      instrSh <= 8'd0;
      data_o  <= 32'd0;
      valid_o <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      state   <= stateNext;
      valid_o <= dataDone;
      err_o   <= reject;

      // One counter serves all three timed phases; it restarts on every
      // state change and is parked at zero while idle.
      if ((state != stateNext) || (state == S_IDLE)) begin
        bitCnt <= 5'd0;
      end else begin
        bitCnt <= bitCnt + 5'd1;
      end

      if (accept) begin
        instrSh <= {1'b1, 2'b00, addr_i};
        lastBit <= 5'({reqBytes, 3'b000} - 6'd1);
      end else if (state == S_INSTR) begin
        instrSh <= {instrSh[6:0], 1'b0};
      end

      // The SIPO's next value already holds the final bit on this edge
      if (dataDone) begin
        data_o <= shiftNext;
      end
    end
  end

  // Cleared on accept, so fewer than 32 received bits are zero-extended
  ad9959_sipo #(
    .DATA_W (32)
  ) uSipo (
    .clk_i     (clk_i),
    .clear     (accept),
    .enable    (shiftEn),
    .serialIn  (sdio2_i),
    .shiftNext (shiftNext)
  );

  // Pin outputs decode directly from the state
  assign csb_o   = !((state == S_INSTR) || (state == S_DATA));
  assign sdio0_o = (state == S_INSTR) && instrSh[7];
  assign busy_o  = (state != S_IDLE);
  assign ready_o = (state == S_IDLE) || !selected;

endmodule

// File: doc/ad9959_readback.md
# ad9959_readback

Register readback engine for one AD9959 DDS card: on a read request it clocks the 8-bit read instruction out on SDIO_0, then deserializes the register contents returned on SDIO_2 (2-wire serial mode) into a 32-bit right-justified word. It sits beside the existing AD9959 write controller on the same card's SPI pins. Card arbitration shares the write controller's `sel_i`/`BRDIDX` scheme. The host command decoder muxes the pins to this block while a CMD_READ (5'h1F) is in progress.

## Interface
- `BRDIDX`, 4'h0, card index; block responds only when `sel_i == BRDIDX`.
- `CSB_GAP`, 4'h2, minimum cycles CSB stays high after a transaction before `ready_o` reasserts (≥1).
- `clk_i` in 1, system clock. The SPI clock pin is driven externally as `~clk_i`, so the device samples mid-cycle on SCLK rise.
- `reset_n_i` in 1, synchronous, active-low reset.
- `sel_i` in 4, card select.
- `start_i` in 1, read request, sampled on `clk_i` rising edge.
- `addr_i` in 5, AD9959 register address, valid with `start_i`.
- `sdio2_i` in 1, serial read data from the device.
- `csb_o` out 1, chip select, active low.
- `sdio0_o` out 1, instruction bit to the device.
- `busy_o` out 1, high while the pins are owned (INSTR/DATA/GAP).
- `ready_o` out 1, high in IDLE; forced 1 when not selected.
- `data_o` out 32, last read value, right-justified, zero-extended.
- `valid_o` out 1, one-cycle pulse when `data_o` updates.
- `err_o` out 1, one-cycle pulse on a rejected request.

## Operation
- The byte count N_B comes from the address:
  - 0x00 → 1
  - 0x01, 0x03, 0x06 → 3
  - 0x02, 0x05, 0x07 → 2
  - 0x04 and 0x08–0x18 → 4
  - 0x19–0x1F → invalid
- N = 8·N_B data bits.
- State machine (S_IDLE, S_INSTR, S_DATA, S_GAP):
  - **S_IDLE**: `csb_o`=1, `sdio0_o`=0. On `start_i` && selected:
    - Invalid address: pulse `err_o`, stay in IDLE, `data_o` unchanged.
    - Valid address: load instruction {1'b1, 2'b00, addr_i}, clear bit counter, go to S_INSTR.
  - **S_INSTR**: 8 cycles, `csb_o`=0, `sdio0_o` = instruction MSB first (bit 7 in the first cycle). Then go to S_DATA.
  - **S_DATA**: N cycles, `csb_o`=0, `sdio0_o`=0. `sdio2_i` is sampled at the `clk_i` edge ending each DATA cycle and shifted into an LSB-in shift register, so the first received bit is the MSB. After the Nth sample:
    - `data_o` ← shift value zero-extended to 32 bits.
    - `valid_o`=1 for one cycle, `csb_o`=1.
    - Go to S_GAP.
  - **S_GAP**: `csb_o`=1 for CSB_GAP cycles, then go to S_IDLE.
- `start_i` outside IDLE is ignored; no queueing.
- `sel_i` changing mid-transaction does not abort it. `ready_o` simply reports 1 while deselected.
- IO_UPDATE is never driven by this block.

## Timing
- Reset (`reset_n_i`=0 at an edge) puts these values on the next cycle: state S_IDLE, `csb_o`=1, `sdio0_o`=0, `busy_o`=0, `ready_o`=1, `data_o`=0, `valid_o`=0, `err_o`=0, counters 0.
- Reset mid-transaction: CSB rises on the next cycle and no `valid_o` is issued.
- If start is sampled at edge E0:
  - `csb_o` falls in cycle E0+1.
  - Instruction occupies cycles E0+1..E0+8.
  - Data samples are taken at edges E0+9..E0+8+N.
  - `valid_o` and `csb_o`=1 appear in cycle E0+9+N.
  - `ready_o`=1 returns in cycle E0+9+N+CSB_GAP.
- Examples: address 0x00 gives `valid_o` 17 cycles after start; 4-byte registers give 41.
- Back-to-back: a `start_i` held high is accepted in the first IDLE cycle.

## Structure
- `ad9959_pkg` holds:
  - register address localparams (CSR, FR1, FR2, CFR, CFTW0, CPOW0, ACR, LSRR, RDW, FDW, CW1..CW15),
  - CMD_READ,
  - state encoding,
  - the function `reg_bytes(addr)` returning 0 for invalid addresses.
- The write controller also uses this package.
- Sub-module `ad9959_sipo`: a 32-bit shift register with clear, enable, and serial input. The FSM and counters stay in the top.

## Test plan
- Address 0x00, device model returns 8'hF6 → instruction 8'h80 on `sdio0_o` MSB first, `data_o`=32'h0000_00F6, `valid_o` 17 cycles after start, CSB low for exactly 16 cycles.
- Address 0x04, returns 32'hDEAD_BEEF → `data_o`=32'hDEAD_BEEF at cycle 41, instruction 8'h84.
- Address 0x01, returns 24'hD0_0300 → `data_o`=32'h00D0_0300, CSB low for exactly 32 cycles.
- Address 0x1A → `err_o` pulses once, `csb_o` stays 1, `data_o` unchanged, `ready_o` stays 1.
- Start on address 0x05, assert `reset_n_i`=0 at cycle 10 → `csb_o`=1 and `data_o`=0 next cycle, no `valid_o`; a new start on address 0x02 then completes normally.
- `start_i` while `sel_i`≠BRDIDX, and a second `start_i` during S_DATA → both ignored, `csb_o` unaffected; `ready_o`=1 while deselected.
